vga_timing_gen: RTL

- Parametrised successor to the fixed 800x600 video generator.
- Produces hs/vs/color from programmable horizontal and vertical timing, with selectable sync polarity.
- Adds a register interface on the CPU data/address bus for enable, background colour, test pattern, frame counter and a vblank interrupt.
- Also exports pixel coordinates and an active flag for a downstream framebuffer fetcher.

---
 rtl/vga_timing_gen.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Programmable raster timing generator. It has two counters, h_cnt (pixels) and
// v_cnt (lines). Each counter steps through four regions in order: active,
// front porch, sync, back porch.
//
// The generator produces the sync pulses (with selectable polarity), a pixel
// colour, an active flag and the pixel coordinates. A downstream framebuffer
// fetcher can use the coordinates and the active flag. All video outputs are
// registered from the current counter values, so they trail the counters by
// one clock.
//
// A small CPU register file sits on an 8-bit address/data bus:
//   0 CTRL   R/W  bit0 en, bit1 mode (0 solid BG, 1 diagonal test pattern),
//                 bit2 irq_en
//   1 BG     R/W  background colour for solid mode
//   2 STATUS R    bit0 vblank, bit1 pend (write 1 to bit1 to clear)
//   3 FRAME  R    8-bit frame counter, bumped on every vblank entry
// Unlisted addresses read 0 and ignore writes.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   data_bus     bidirectional CPU data; driven only while r=1
//   address_bus  register address
//   w            write strobe, sampled on the rising clk edge
//   r            read strobe; read data is combinational from the registers
//   hs, vs       sync outputs (registered)
//   color        pixel colour (registered)
//   active       high while color lies in the visible area (registered)
//   pixel_x/y    coordinates of the pixel being shown (registered)
//   irq          level interrupt, STATUS.pend & CTRL.irq_en
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int         H_ACTIVE    = 800,
    parameter int         H_FP        = 40,
    parameter int         H_SYNC      = 128,
    parameter int         H_BP        = 88,
    parameter int         V_ACTIVE    = 600,
    parameter int         V_FP        = 1,
    parameter int         V_SYNC      = 4,
    parameter int         V_BP        = 23,
    parameter logic       HS_POL      = 1'b1,
    parameter logic       VS_POL      = 1'b1,
    parameter logic [7:0] BLANK_COLOR = 8'hF8,
    parameter int         CNT_W       = 11
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [7:0]       data_bus,
    input  logic [7:0]       address_bus,
    input  logic             w,
    input  logic             r,
    output logic             hs,
    output logic             vs,
    output logic [7:0]       color,
    output logic             active,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [7:0] ADDR_CTRL   = 8'd0;
    localparam logic [7:0] ADDR_BG     = 8'd1;
    localparam logic [7:0] ADDR_STATUS = 8'd2;
    localparam logic [7:0] ADDR_FRAME  = 8'd3;

    // Solid mode shows the background register. Test-pattern mode shows a
    // diagonal ramp, which is the low byte of h+v and wraps mod 256.
    function automatic logic [7:0] pick_color(
        input logic             mode,
        input logic [7:0]       bg_val,
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] v
    );
        logic [CNT_W-1:0] sum;
        sum = h + v;
        return mode ? sum[7:0] : bg_val;
    endfunction

    // Register file and counter state
    logic             ctrl_en;
    logic             ctrl_mode;
    logic             ctrl_irq_en;
    logic [7:0]       bg;
    logic             pend;
    logic [7:0]       frame_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic       wr_ctrl;
    logic       wr_bg;
    logic       wr_status;
    logic       h_wrap;
    logic       frame_evt;
    logic       vblank;
    logic [7:0] rdata;

    assign wr_ctrl   = w && (address_bus == ADDR_CTRL);
    assign wr_bg     = w && (address_bus == ADDR_BG);
    assign wr_status = w && (address_bus == ADDR_STATUS);

    assign h_wrap = (h_cnt == H_LAST);

    // The frame event fires on the edge that moves the counters onto
    // (0, V_ACTIVE), which is the first blank line of the frame.
    assign frame_evt = ctrl_en && h_wrap && (v_cnt == V_VIS_LAST);

    assign vblank = (v_cnt >= V_VIS);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en     <= 1'b1;
            ctrl_mode   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            bg          <= 8'h00;
            pend        <= 1'b0;
            frame_cnt   <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= data_bus[0];
                ctrl_mode   <= data_bus[1];
                ctrl_irq_en <= data_bus[2];
            end
            if (wr_bg) begin
                bg <= data_bus;
            end
            // A new frame event beats a simultaneous write-1-to-clear so that
            // an interrupt is never silently dropped.
            if (frame_evt) begin
                pend      <= 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (wr_status && data_bus[1]) begin
                pend <= 1'b0;
            end
        end
    end

    // While disabled, the counters park at the origin. Re-enabling therefore
    // starts a clean frame at (0,0).
    always_ff @(posedge clk) begin
        if (reset || !ctrl_en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // ---- p0: region decode from the live counters ----
    logic       h_vis_p0;
    logic       v_vis_p0;
    logic       vis_p0;
    logic       hs_on_p0;
    logic       vs_on_p0;
    logic [7:0] color_p0;

    always_comb begin
        h_vis_p0 = (h_cnt < H_VIS);
        v_vis_p0 = (v_cnt < V_VIS);
        vis_p0   = h_vis_p0 && v_vis_p0;
        hs_on_p0 = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vs_on_p0 = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        color_p0 = vis_p0 ? pick_color(ctrl_mode, bg, h_cnt, v_cnt) : BLANK_COLOR;
    end

    // ---- p1: registered video outputs, one clock behind the counters ----
    logic             hs_p1;
    logic             vs_p1;
    logic [7:0]       color_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] px_p1;
    logic [CNT_W-1:0] py_p1;

    always_ff @(posedge clk) begin
        if (reset || !ctrl_en) begin
            hs_p1    <= ~HS_POL;
            vs_p1    <= ~VS_POL;
            color_p1 <= BLANK_COLOR;
            vld_p1   <= 1'b0;
            px_p1    <= '0;
            py_p1    <= '0;
        end else begin
            hs_p1    <= hs_on_p0 ? HS_POL : ~HS_POL;
            vs_p1    <= vs_on_p0 ? VS_POL : ~VS_POL;
            color_p1 <= color_p0;
            vld_p1   <= vis_p0;
            // Coordinates only advance inside the visible area. In the blanking
            // regions they keep the last drawn pixel.
            if (vis_p0) begin
                px_p1 <= h_cnt;
                py_p1 <= v_cnt;
            end
        end
    end

    assign hs      = hs_p1;
    assign vs      = vs_p1;
    assign color   = color_p1;
    assign active  = vld_p1;
    assign pixel_x = px_p1;
    assign pixel_y = py_p1;

    assign irq = pend && ctrl_irq_en;

    // The read mux is purely combinational. A read in the same cycle as a
    // write therefore sees the value from before the write.
    always_comb begin
        rdata = 8'h00;
        case (address_bus)
            ADDR_CTRL:   rdata = {5'b00000, ctrl_irq_en, ctrl_mode, ctrl_en};
            ADDR_BG:     rdata = bg;
            ADDR_STATUS: rdata = {6'b000000, pend, vblank};
            ADDR_FRAME:  rdata = frame_cnt;
            default:     rdata = 8'h00;
        endcase
    end

    assign data_bus = r ? rdata : 8'bzzzz_zzzz;

endmodule
